// File: rtl/ram_pkg.sv
// Shared definitions for the RAM BIST controller: FSM state encoding and the
// test pattern generator, which the compare stage also uses.
package ram_pkg;

    localparam int unsigned PAT_W = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bist_state_t;

    // P(a) = a ^ seed, optionally inverted; callers truncate to their word width.
    function automatic logic [PAT_W-1:0] pat_word(
        input logic [PAT_W-1:0] a,
        input logic [PAT_W-1:0] seed,
        input logic             invert
    );
        return (a ^ seed) ^ {PAT_W{invert}};
    endfunction

endpackage

// File: rtl/bist_cmp.sv
// BIST compare stage: registers each read address, checks the RAM's registered
// output one cycle later, counts mismatches and latches the first failing address.
module bist_cmp
    import ram_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 3,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_rd_fire,
    input  logic [addr_width-1:0] i_rd_addr,
    input  logic                  i_rd_inv,
    input  logic [data_width-1:0] i_ram_dout,
    output logic [addr_width+1:0] o_err_count,
    output logic [addr_width-1:0] o_fail_addr,
    output logic                  o_mismatch_c
);

    localparam int unsigned      CNT_W   = addr_width + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                  r_valid;
    logic [addr_width-1:0] r_addr;
    logic                  r_inv;
    logic                  r_first_seen;
    logic [data_width-1:0] w_expected;

    assign w_expected   = data_width'(pat_word(PAT_W'(r_addr), PAT_W'(SEED), r_inv));
    assign o_mismatch_c = r_valid && (i_ram_dout != w_expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_inv        <= 1'b0;
            r_first_seen <= 1'b0;
            o_err_count  <= '0;
            o_fail_addr  <= '0;
        end else if (i_clr) begin
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_inv        <= 1'b0;
            r_first_seen <= 1'b0;
            o_err_count  <= '0;
            o_fail_addr  <= '0;
        end else begin
            r_valid <= i_rd_fire;
            r_addr  <= i_rd_addr;
            r_inv   <= i_rd_inv;
            if (o_mismatch_c) begin
                if (o_err_count != CNT_MAX) begin
                    o_err_count <= o_err_count + CNT_W'(1);
                end
                if (!r_first_seen) begin
                    o_fail_addr  <= r_addr;
                    r_first_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// BIST initiator for a single-port synchronous RAM: writes/reads back a seeded
// pattern over every address, then repeats with the inverted pattern.
module ram_bist_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 3,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_din,
    output logic                  ram_we,
    input  logic [data_width-1:0] ram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [addr_width+1:0] err_count,
    output logic [addr_width-1:0] fail_addr
);

    localparam logic [addr_width-1:0] ADDR_LAST = {addr_width{1'b1}};

    bist_state_t           r_state;
    logic [addr_width-1:0] r_addr;
    logic                  r_pass_idx;

    logic                  w_accept;
    logic                  w_rd_fire;
    logic                  w_mismatch;
    logic [addr_width-1:0] w_addr_inc;

    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_rd_fire  = (r_state == RD);
    assign w_addr_inc = r_addr + addr_width'(1);

    function automatic logic [data_width-1:0] f_pat(
        input logic [addr_width-1:0] a,
        input logic                  inv
    );
        return data_width'(pat_word(PAT_W'(a), PAT_W'(SEED), inv));
    endfunction

    bist_cmp #(
        .data_width (data_width),
        .addr_width (addr_width),
        .SEED       (SEED)
    ) u_cmp (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_accept),
        .i_rd_fire    (w_rd_fire),
        .i_rd_addr    (r_addr),
        .i_rd_inv     (r_pass_idx),
        .i_ram_dout   (ram_dout),
        .o_err_count  (err_count),
        .o_fail_addr  (fail_addr),
        .o_mismatch_c (w_mismatch)
    );

    // Sequencer: outputs are registered so each state's RAM command is on the pins while in it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_pass_idx <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= WR;
                        r_addr     <= '0;
                        r_pass_idx <= 1'b0;
                        ram_addr   <= '0;
                        ram_din    <= f_pat('0, 1'b0);
                        ram_we     <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                WR: begin
                    if (r_addr == ADDR_LAST) begin
                        r_state  <= RD;
                        r_addr   <= '0;
                        ram_addr <= '0;
                        ram_din  <= '0;
                        ram_we   <= 1'b0;
                    end else begin
                        r_addr   <= w_addr_inc;
                        ram_addr <= w_addr_inc;
                        ram_din  <= f_pat(w_addr_inc, r_pass_idx);
                    end
                end
                RD: begin
                    if (r_addr == ADDR_LAST) begin
                        r_state <= DRAIN;
                        r_addr  <= '0;
                    end else begin
                        r_addr   <= w_addr_inc;
                        ram_addr <= w_addr_inc;
                    end
                end
                DRAIN: begin
                    if (!r_pass_idx) begin
                        r_state    <= WR;
                        r_pass_idx <= 1'b1;
                        r_addr     <= '0;
                        ram_addr   <= '0;
                        ram_din    <= f_pat('0, 1'b1);
                        ram_we     <= 1'b1;
                    end else begin
                        // The last word is being compared this cycle, so fold it into pass.
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == '0) && !w_mismatch;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
